serial_nibble_adder_ctrl: RTL and testbench

Multi-cycle controller that computes a WIDTH-bit add or subtract by running one 4-bit carry-lookahead slice (Carry_Lookahead_4) over the operands, one nibble per clock, least-significant first. It captures operands on a start handshake, steers nibbles and the running carry into the slice, and shifts the 4-bit sums into a result register. It reports carry, signed overflow and zero flags. It sits beside the ALU as a small-area alternative to a full-width parallel adder.

---
 rtl/serial_nibble_adder_ctrl.sv | 157 +++++++++++++++
 tb/tb_serial_nibble_adder_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_nibble_adder_ctrl.sv
// Serial WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice,
// processing one nibble per clock, least-significant nibble first.

module Carry_Lookahead_4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       carry_0,
    output logic [3:0] s,
    output logic       carry_4
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = x & y;
    assign p = x ^ y;

    assign c[0]    = carry_0;
    assign c[1]    = g[0] | (p[0] & carry_0);
    assign c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_0);
    assign c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                   | (p[2] & p[1] & p[0] & carry_0);
    assign carry_4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0])
                   | (p[3] & p[2] & p[1] & p[0] & carry_0);
    assign s       = p ^ c;
endmodule

module serial_nibble_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [1:0]       dbg_state_o
);
    localparam int N     = WIDTH / 4;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;

    logic [3:0]       nib_sum;
    logic             nib_carry;
    logic [WIDTH-1:0] sr_d;
    logic             ovf_d;

    Carry_Lookahead_4 u_cla (
        .x       (op_a_q[3:0]),
        .y       (op_b_q[3:0]),
        .carry_0 (c_q),
        .s       (nib_sum),
        .carry_4 (nib_carry)
    );

    // New nibble enters at the top so the first (LSB) nibble ends at bit 0.
    assign sr_d  = {nib_sum, {(WIDTH-4){1'b0}}} | (sr_q >> 4);
    assign ovf_d = (a_msb_q ~^ b_msb_q) & (a_msb_q ^ nib_sum[3]);

    // Handshake: start is a request with no ready; it is taken on any rising
    // edge where busy is low (IDLE or DONE) and ignored while busy is high.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            c_q      <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_a_q  <= a;
                        op_b_q  <= sub ? ~b : b;
                        c_q     <= sub;
                        cnt_q   <= '0;
                        sr_q    <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= b[WIDTH-1] ^ sub;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sr_q   <= sr_d;
                    op_a_q <= op_a_q >> 4;
                    op_b_q <= op_b_q >> 4;
                    c_q    <= nib_carry;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    // Visible result and flags are only published here.
                    if (cnt_q == CNT_LAST) begin
                        result_q <= sr_d;
                        carry_q  <= nib_carry;
                        ovf_q    <= ovf_d;
                        zero_q   <= ~|sr_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign carry_out   = carry_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_serial_nibble_adder_ctrl.sv
// Bench for serial_nibble_adder_ctrl: directed operations checked against
// hand-computed values plus a per-cycle comparison with an arithmetic model.

module tb_serial_nibble_adder_ctrl;
  localparam int W  = 32;
  localparam int N  = W / 4;
  localparam int EW = W + 3;
  localparam longint SMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint SMIN = -SMAX - 64'sd1;

  // clock / reset
  logic clk = 1'b0;
  logic clr;
  logic start;
  logic sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic busy, done, carry_out, overflow, zero;
  logic [W-1:0] result;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  serial_nibble_adder_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .sub         (sub),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .carry_out   (carry_out),
    .overflow    (overflow),
    .zero        (zero),
    .dbg_state_o (dbg_state)
  );

  int vectors = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model: {result, carry, overflow, zero} from plain arithmetic
  function automatic logic [EW-1:0] model_calc(input logic [W-1:0] av, input logic [W-1:0] bv,
                                               input logic sv);
    longint sa, sb, tr;
    longint unsigned ua, ub;
    logic [W-1:0] r;
    logic c, v;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = 64'(av);
    ub = 64'(bv);
    if (sv) begin
      r  = av - bv;
      c  = (ua >= ub);
      tr = sa - sb;
    end else begin
      r  = av + bv;
      c  = ((ua + ub) >= (64'd1 << W));
      tr = sa + sb;
    end
    v = (tr > SMAX) || (tr < SMIN);
    return {r, c, v, (r == '0)};
  endfunction

  // scoreboard: expected queue plus cycle-level busy/done expectation
  logic [EW-1:0] exp_q[$];
  logic m_busy, m_done;
  logic [EW-1:0] m_out;
  int m_left;

  always @(posedge clk) begin
    if (clr) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_out  = '0;
      m_left = 0;
      exp_q.delete();
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_out  = exp_q.pop_front();
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1;
        m_left = N;
        exp_q.push_back(model_calc(a, b, sub));
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if ({busy, done, result, carry_out, overflow, zero} !== {m_busy, m_done, m_out}) begin
          fails++;
          $display("FAIL cycle t=%0t: got busy=%b done=%b res=%h c=%b v=%b z=%b, expected busy=%b done=%b res=%h c=%b v=%b z=%b",
                   $time, busy, done, result, carry_out, overflow, zero,
                   m_busy, m_done, m_out[EW-1:3], m_out[2], m_out[1], m_out[0]);
        end
      end
    end
  endtask

  // driver: call at a negedge; returns at the negedge where done is seen
  task automatic do_op(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic [W-1:0] er, input logic ec,
                       input logic ev, input logic ez, input bit poke);
    int lat;
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (poke && lat == 2) begin
        start = 1'b1;
        a = 32'hFFFF_0000;
        b = 32'h0000_FFFF;
        sub = 1'b1;
      end else if (poke && lat == 3) begin
        start = 1'b0;
      end
    end
    chk({nm, " latency"}, 64'(lat), 64'(N));
    chk({nm, " result"}, 64'(result), 64'(er));
    chk({nm, " flags c/v/z"}, 64'({carry_out, overflow, zero}), 64'({ec, ev, ez}));
  endtask

  initial begin
    int nd;
    clr = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    fork
      compare_loop();
    join_none
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset outputs", 64'({busy, done, result, carry_out, overflow, zero}), 64'd0);
    clr = 1'b0;

    @(negedge clk);
    do_op("add wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_op("signed ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_op("5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("7-5", 32'd7, 32'd5, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("0-0", 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    do_op("min-1", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);

    // abort in the third RUN cycle
    @(negedge clk);
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    sub = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr outputs", 64'({busy, done, result, carry_out, overflow, zero}), 64'd0);
    clr = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no done after clr", 64'(nd), 64'd0);
    do_op("after clr", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);

    // start pulsed during RUN, then back-to-back start held in DONE
    @(negedge clk);
    do_op("busy poke", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("back2back", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("idle after ops", 64'({busy, done}), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
